spi_slave_word_core: RTL and testbench

SPI_SLAVE_WORD_CORE -- requirements
Module: spi_slave_word_core

---
 rtl/spi_slave_pkg.sv | 30 +++
 rtl/spi_slave_sync.sv | 27 ++
 rtl/spi_slave_word_core.sv | 199 +++++++++++++++++++
 tb/tb_spi_slave_word_core.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/spi_slave_pkg.sv
// Shared definitions for the SPI slave word core: FSM state encoding,
// SPI mode constants and the default idle transmit word.
package spi_slave_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2
    } state_t;

    // SPI mode encoding {CPOL,CPHA}
    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

    // Word shifted out when no transmit word is offered (sliced to DATA_W)
    localparam logic [31:0] TX_IDLE_DEFAULT = '1;

    // Clock polarity: SCLK idles high in modes 2 and 3
    function automatic logic mode_cpol(input logic [1:0] m);
        return (m == MODE2) || (m == MODE3);
    endfunction

    // Clock phase: sample on the trailing edge in modes 1 and 3
    function automatic logic mode_cpha(input logic [1:0] m);
        return !((m == MODE0) || (m == MODE2));
    endfunction

endpackage

// File: rtl/spi_slave_sync.sv
// Two-flop synchronizer for one asynchronous SPI pin, followed by one
// edge-detect register. IDLE_VAL is the level all flops take on reset.
module spi_slave_sync #(
    parameter logic IDLE_VAL = 1'b0
) (
    input  logic sys_clk,
    input  logic rst,
    input  logic pin,
    output logic lvl,
    output logic rise,
    output logic fall
);

    // sr[1:0] is the synchronizer, sr[2] holds the previous synchronized level
    logic [2:0] sr;

    // Shift the raw pin through the synchronizer and edge-detect stage
    always_ff @(posedge sys_clk) begin
        if (rst) sr <= {3{IDLE_VAL}};
        else     sr <= {sr[1:0], pin};
    end

    assign lvl  = sr[1];
    assign rise = sr[1] & ~sr[2];
    assign fall = ~sr[1] & sr[2];

endmodule

// File: rtl/spi_slave_word_core.sv
// SPI slave, word oriented, all four SPI modes, oversampled on sys_clk.
// Optional statistics counters are enabled by defining SPI_SLAVE_STATS_EN.
module spi_slave_word_core
    import spi_slave_pkg::*;
#(
    parameter int              DATA_W    = 8,
    parameter int              LSB_FIRST = 0,
    parameter logic [DATA_W-1:0] TX_IDLE = TX_IDLE_DEFAULT[DATA_W-1:0]
) (
    input  logic              sys_clk,
    input  logic              rst,
    input  logic [1:0]        cfg_mode,
    input  logic              st_spi_clk,
    input  logic              st_spi_mosi,
    input  logic              st_spi_ncs,
    output logic              st_spi_miso,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              rx_fval,
    output logic              rx_partial,
    output logic              tx_underrun
`ifdef SPI_SLAVE_STATS_EN
    ,
    output logic [15:0]       stat_frames,
    output logic [15:0]       stat_words,
    output logic [15:0]       stat_underruns
`endif
);

    localparam int CW = $clog2(DATA_W);

    // Pin order {ncs, clk, mosi}; ncs idles high, the rest low
    localparam logic [2:0] SYNC_IDLE = 3'b100;

    logic [2:0] pins, s_lvl, s_rise, s_fall;
    assign pins = {st_spi_ncs, st_spi_clk, st_spi_mosi};

    for (genvar i = 0; i < 3; i++) begin : g_sync
        spi_slave_sync #(.IDLE_VAL(SYNC_IDLE[i])) u_sync (
            .sys_clk (sys_clk),
            .rst     (rst),
            .pin     (pins[i]),
            .lvl     (s_lvl[i]),
            .rise    (s_rise[i]),
            .fall    (s_fall[i])
        );
    end

    logic ncs_lvl, ncs_rise, ncs_fall, clk_rise, clk_fall, mosi_lvl;
    assign ncs_lvl  = s_lvl[2];
    assign ncs_rise = s_rise[2];
    assign ncs_fall = s_fall[2];
    assign clk_rise = s_rise[1];
    assign clk_fall = s_fall[1];
    assign mosi_lvl = s_lvl[0];

    logic sync_unused;
    assign sync_unused = &{s_lvl[1], s_rise[0], s_fall[0]};

    state_t            state;
    logic [1:0]        mode;
    logic [CW-1:0]     bit_cnt;
    logic [DATA_W-1:0] rx_shift, tx_shift, tx_hold;
    logic              skip_shift;   // CPHA=1: first shift edge keeps bit 0
    logic              reload;       // next shift edge loads tx_hold
    logic [1:0]        arm_cnt;      // ncs seen high long enough after reset

    logic              lead_edge, trail_edge, sample_ev, shift_ev;
    logic              last_bit, word_done, partial_end;
    logic [DATA_W-1:0] fetch_word, rx_next, tx_adv, tx_next;
    logic              miso_next;

    // Edge classification, fetch handshake and next shift-register values
    always_comb begin
        lead_edge   = mode_cpol(mode) ? clk_fall : clk_rise;
        trail_edge  = mode_cpol(mode) ? clk_rise : clk_fall;
        sample_ev   = (state == ST_SHIFT) && (mode_cpha(mode) ? trail_edge : lead_edge);
        shift_ev    = (state == ST_SHIFT) && (mode_cpha(mode) ? lead_edge : trail_edge);
        last_bit    = (bit_cnt == CW'(DATA_W - 1));
        word_done   = sample_ev && last_bit;
        partial_end = sample_ev ? !last_bit : (bit_cnt != '0);
        // No fetch when the frame ends on the same cycle: that word would never go out
        tx_ready    = (state == ST_LOAD) || (word_done && !ncs_rise);
        fetch_word  = tx_valid ? tx_data : TX_IDLE;
        if (LSB_FIRST != 0) begin
            rx_next = {mosi_lvl, rx_shift[DATA_W-1:1]};
            tx_adv  = {1'b0, tx_shift[DATA_W-1:1]};
        end else begin
            rx_next = {rx_shift[DATA_W-2:0], mosi_lvl};
            tx_adv  = {tx_shift[DATA_W-2:0], 1'b0};
        end
        tx_next = tx_shift;
        if (state == ST_LOAD)  tx_next = fetch_word;
        else if (shift_ev && !skip_shift) tx_next = reload ? tx_hold : tx_adv;
        miso_next = (LSB_FIRST != 0) ? tx_next[0] : tx_next[DATA_W-1];
    end

    // Frame FSM with registered outputs
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            mode        <= MODE0;
            bit_cnt     <= '0;
            rx_shift    <= '0;
            tx_shift    <= TX_IDLE;
            tx_hold     <= TX_IDLE;
            skip_shift  <= 1'b0;
            reload      <= 1'b0;
            arm_cnt     <= 2'd0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            rx_fval     <= 1'b0;
            rx_partial  <= 1'b0;
            tx_underrun <= 1'b0;
            st_spi_miso <= 1'b1;
        end else begin
            rx_valid    <= 1'b0;
            rx_partial  <= 1'b0;
            tx_underrun <= tx_ready && !tx_valid;
            tx_shift    <= tx_next;
            // The ncs synchronizer leaves reset reading high; insist on a real
            // high level before honouring a falling edge so a frame already in
            // progress at reset release is not picked up mid-way.
            if (arm_cnt != 2'd3) arm_cnt <= ncs_lvl ? arm_cnt + 2'd1 : 2'd0;
            case (state)
                ST_IDLE: begin
                    st_spi_miso <= 1'b1;
                    if (ncs_fall && arm_cnt == 2'd3) begin
                        state   <= ST_LOAD;
                        rx_fval <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    mode        <= cfg_mode;
                    bit_cnt     <= '0;
                    skip_shift  <= mode_cpha(cfg_mode);
                    reload      <= 1'b0;
                    st_spi_miso <= miso_next;
                    state       <= ST_SHIFT;
                    if (ncs_rise) begin
                        state       <= ST_IDLE;
                        rx_fval     <= 1'b0;
                        st_spi_miso <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    st_spi_miso <= miso_next;
                    if (sample_ev) begin
                        rx_shift <= rx_next;
                        bit_cnt  <= last_bit ? '0 : bit_cnt + 1'b1;
                        if (last_bit) begin
                            rx_data  <= rx_next;
                            rx_valid <= 1'b1;
                            if (!ncs_rise) begin
                                tx_hold <= fetch_word;
                                reload  <= 1'b1;
                            end
                        end
                    end
                    if (shift_ev) begin
                        skip_shift <= 1'b0;
                        if (!skip_shift) reload <= 1'b0;
                    end
                    if (ncs_rise) begin
                        state       <= ST_IDLE;
                        rx_fval     <= 1'b0;
                        st_spi_miso <= 1'b1;
                        rx_partial  <= partial_end;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef SPI_SLAVE_STATS_EN
    // Saturating frame, word and underrun counters
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            stat_frames    <= '0;
            stat_words     <= '0;
            stat_underruns <= '0;
        end else begin
            if (state == ST_SHIFT && ncs_rise && stat_frames != 16'hFFFF)
                stat_frames <= stat_frames + 16'd1;
            if (rx_valid && stat_words != 16'hFFFF)
                stat_words <= stat_words + 16'd1;
            if (tx_underrun && stat_underruns != 16'hFFFF)
                stat_underruns <= stat_underruns + 16'd1;
        end
    end
`else
    // Statistics counters not built
`endif

endmodule

// File: tb/tb_spi_slave_word_core.sv
// Directed bench: one 8-bit MSB-first core and one 16-bit LSB-first core
// share SCLK/MOSI with separate chip selects. SPI_SLAVE_STATS_EN adds the
// statistics section.
module tb_spi_slave_word_core;

    localparam int HALF = 80;   // SCLK half period, 16 sys_clk per SCLK

    logic        sys_clk = 1'b0;
    logic        rst;
    logic [1:0]  cfg_mode;
    logic        sclk, mosi, ncs8, ncs16;
    logic        miso8, miso16;
    logic [7:0]  tx_data8, rx_data8;
    logic [15:0] tx_data16, rx_data16;
    logic        tx_valid8, tx_ready8, rx_valid8, rx_fval8, rx_partial8, tx_underrun8;
    logic        tx_valid16, tx_ready16, rx_valid16, rx_fval16, rx_partial16, tx_underrun16;
`ifdef SPI_SLAVE_STATS_EN
    logic [15:0] sf8, sw8, su8, sf16, sw16, su16;
`endif

    always #5 sys_clk = ~sys_clk;

    spi_slave_word_core #(.DATA_W(8), .LSB_FIRST(0)) dut8 (
        .sys_clk(sys_clk), .rst(rst), .cfg_mode(cfg_mode),
        .st_spi_clk(sclk), .st_spi_mosi(mosi), .st_spi_ncs(ncs8), .st_spi_miso(miso8),
        .tx_data(tx_data8), .tx_valid(tx_valid8), .tx_ready(tx_ready8),
        .rx_data(rx_data8), .rx_valid(rx_valid8), .rx_fval(rx_fval8),
        .rx_partial(rx_partial8), .tx_underrun(tx_underrun8)
`ifdef SPI_SLAVE_STATS_EN
        , .stat_frames(sf8), .stat_words(sw8), .stat_underruns(su8)
`endif
    );

    spi_slave_word_core #(.DATA_W(16), .LSB_FIRST(1)) dut16 (
        .sys_clk(sys_clk), .rst(rst), .cfg_mode(cfg_mode),
        .st_spi_clk(sclk), .st_spi_mosi(mosi), .st_spi_ncs(ncs16), .st_spi_miso(miso16),
        .tx_data(tx_data16), .tx_valid(tx_valid16), .tx_ready(tx_ready16),
        .rx_data(rx_data16), .rx_valid(rx_valid16), .rx_fval(rx_fval16),
        .rx_partial(rx_partial16), .tx_underrun(tx_underrun16)
`ifdef SPI_SLAVE_STATS_EN
        , .stat_frames(sf16), .stat_words(sw16), .stat_underruns(su16)
`endif
    );

    // Strobe monitors: count high cycles, collect 16-bit words
    int n_v8 = 0, n_r8 = 0, n_u8 = 0, n_p8 = 0, n_v16 = 0, n_r16 = 0;
    logic [15:0] w16[$];
    always @(posedge sys_clk) begin
        if (rx_valid8)    n_v8++;
        if (tx_ready8)    n_r8++;
        if (tx_underrun8) n_u8++;
        if (rx_partial8)  n_p8++;
        if (rx_valid16) begin
            n_v16++;
            w16.push_back(rx_data16);
        end
        if (tx_ready16)   n_r16++;
    end

    int  total = 0, bad = 0;
    bit  use16 = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic frame_begin(input logic [1:0] m);
        cfg_mode = m;
        sclk     = m[1];
        #200;
        if (use16) ncs16 = 1'b0;
        else       ncs8  = 1'b0;
        #200;
    endtask

    task automatic frame_end();
        #HALF;
        ncs8  = 1'b1;
        ncs16 = 1'b1;
        #300;
    endtask

    // Master side: shift n bits of d, capture MISO just before each sample edge
    task automatic xfer(input int n, input logic [31:0] d, input bit lsb, output logic [31:0] got);
        logic cpol, cpha;
        int   idx;
        cpol = cfg_mode[1];
        cpha = cfg_mode[0];
        got  = '0;
        for (int i = 0; i < n; i++) begin
            idx = lsb ? i : n - 1 - i;
            if (!cpha) begin
                mosi = d[idx];
                #HALF;
                got[idx] = use16 ? miso16 : miso8;
                sclk = ~cpol;
                #HALF;
                sclk = cpol;
            end else begin
                sclk = ~cpol;
                mosi = d[idx];
                #HALF;
                got[idx] = use16 ? miso16 : miso8;
                sclk = cpol;
                #HALF;
            end
        end
    endtask

    initial begin
        logic [31:0] got, g1, g2;
        int bv, br, bu, bp, bv16, br16;
        rst = 1'b1; cfg_mode = 2'b00; sclk = 1'b0; mosi = 1'b0;
        ncs8 = 1'b1; ncs16 = 1'b1;
        tx_data8 = 8'h00; tx_valid8 = 1'b0; tx_data16 = 16'h0000; tx_valid16 = 1'b0;
        #100;
        @(negedge sys_clk);
        check("rst_miso",     miso8, 1);
        check("rst_rx_data",  rx_data8, 0);
        check("rst_rx_valid", rx_valid8, 0);
        check("rst_fval",     rx_fval8, 0);
        check("rst_partial",  rx_partial8, 0);
        check("rst_underrun", tx_underrun8, 0);
        check("rst_tx_ready", tx_ready8, 0);
        rst = 1'b0;
        repeat (5) @(negedge sys_clk);

        // Mode 0, MSB first: receive 0xA5 while sending 0x3C
        tx_data8 = 8'h3C; tx_valid8 = 1'b1;
        bv = n_v8; br = n_r8; bu = n_u8;
        frame_begin(2'b00);
        check("m0_fval_mid", rx_fval8, 1);
        xfer(8, 32'hA5, 1'b0, got);
        frame_end();
        check("m0_rx_data",  rx_data8, 8'hA5);
        check("m0_valid_n",  n_v8 - bv, 1);
        check("m0_miso",     got, 8'h3C);
        check("m0_ready_n",  n_r8 - br, 2);
        check("m0_under_n",  n_u8 - bu, 0);
        check("m0_fval_end", rx_fval8, 0);

        // Mode 3, 16-bit LSB first, two back-to-back words
        use16 = 1'b1;
        tx_data16 = 16'hC0DE; tx_valid16 = 1'b1;
        bv16 = n_v16; br16 = n_r16;
        frame_begin(2'b11);
        tx_data16 = 16'h55AA;
        xfer(16, 32'h1234, 1'b1, g1);
        xfer(16, 32'hBEEF, 1'b1, g2);
        frame_end();
        use16 = 1'b0;
        check("m3_valid_n", n_v16 - bv16, 2);
        check("m3_nwords",  w16.size(), 2);
        check("m3_word0",   (w16.size() > 0) ? w16[0] : 16'hxxxx, 16'h1234);
        check("m3_word1",   (w16.size() > 1) ? w16[1] : 16'hxxxx, 16'hBEEF);
        check("m3_miso0",   g1, 16'hC0DE);
        check("m3_miso1",   g2, 16'h55AA);
        check("m3_ready_n", n_r16 - br16, 3);

        // Mode 1 with nothing to send: idle word goes out, underrun per fetch
        tx_valid8 = 1'b0;
        bv = n_v8; bu = n_u8;
        frame_begin(2'b01);
        xfer(8, 32'h96, 1'b0, got);
        frame_end();
        check("m1_miso",    got, 8'hFF);
        check("m1_under_n", n_u8 - bu, 2);
        check("m1_rx_data", rx_data8, 8'h96);
        check("m1_valid_n", n_v8 - bv, 1);

        // Frame cut after 5 of 8 bits
        tx_valid8 = 1'b1;
        bv = n_v8; bp = n_p8;
        frame_begin(2'b00);
        xfer(5, 32'h1B, 1'b0, got);
        frame_end();
        check("part_n",       n_p8 - bp, 1);
        check("part_valid_n", n_v8 - bv, 0);
        check("part_rx_data", rx_data8, 8'h96);

        // Reset after 3 bits of a mode 2 frame, then a clean frame
        bv = n_v8; bp = n_p8;
        frame_begin(2'b10);
        xfer(3, 32'h7, 1'b0, got);
        @(negedge sys_clk) rst = 1'b1;
        @(negedge sys_clk) rst = 1'b0;
        check("rsta_rx_data", rx_data8, 0);
        check("rsta_miso",    miso8, 1);
        check("rsta_fval",    rx_fval8, 0);
        check("rsta_valid",   rx_valid8, 0);
        repeat (20) @(negedge sys_clk);
        check("rsta_no_load", rx_fval8, 0);
        ncs8 = 1'b1;
        #300;
        frame_begin(2'b10);
        xfer(8, 32'h5A, 1'b0, got);
        frame_end();
        check("rsta_rx_new",  rx_data8, 8'h5A);
        check("rsta_valid_n", n_v8 - bv, 1);
        check("rsta_part_n",  n_p8 - bp, 0);
        check("rsta_miso_w",  got, 8'h3C);

`ifdef SPI_SLAVE_STATS_EN
        // Three 2-word frames, only the first LOAD fetch starved
        @(negedge sys_clk) rst = 1'b1;
        @(negedge sys_clk) rst = 1'b0;
        repeat (5) @(negedge sys_clk);
        for (int f = 0; f < 3; f++) begin
            tx_valid8 = (f != 0);
            frame_begin(2'b00);
            tx_valid8 = 1'b1;
            xfer(8, 32'h11 * (f + 1), 1'b0, got);
            xfer(8, 32'h22 * (f + 1), 1'b0, got);
            frame_end();
        end
        check("stat_frames",    sf8, 3);
        check("stat_words",     sw8, 6);
        check("stat_underruns", su8, 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
